// File: rtl/spi_master.sv
// Full-duplex SPI master with configurable word width and CPOL/CPHA mode.
// Captures MISO, pulses DONE per word and can hold chip select across words.
module spi_master #(
   parameter int CLK_FREQ   = 100000000,
   parameter int SPI_FREQ   = 1000000,
   parameter int DATA_WIDTH = 8,
   parameter bit CPOL       = 1'b0,
   parameter bit CPHA       = 1'b0
) (
   input  logic                  CLK_100MHz,
   input  logic                  RESET_N,
   input  logic                  LOAD,
   input  logic                  KEEP_CS,
   input  logic                  DROP_CS,
   input  logic [DATA_WIDTH-1:0] IN,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [DATA_WIDTH-1:0] OUT,
   output logic                  SCK,
   output logic                  SDI,
   input  logic                  SDO,
   output logic                  CSX
);

   localparam int HALF_RAW = CLK_FREQ / SPI_FREQ / 2;
   localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
   localparam int CNT_W    = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int EDGES    = 2 * DATA_WIDTH;
   localparam int EDGE_W   = $clog2(EDGES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HALF - 1);
   localparam logic [EDGE_W-1:0] EDGE_PEN = EDGE_W'(EDGES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_HELD, S_GAP
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [EDGE_W-1:0]     edge_cnt_q, edge_cnt_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic                  keep_q, keep_d;
   logic                  sck_q, sck_d;
   logic                  sdi_q, sdi_d;
   logic                  csx_q, csx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  half_end;
   logic                  start;

   // NOTE: every _d gets a default before the case so no path leaves a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      edge_cnt_d = edge_cnt_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      out_d      = out_q;
      keep_d     = keep_q;
      sck_d      = sck_q;
      sdi_d      = sdi_q;
      csx_d      = csx_q;
      done_d     = 1'b0;
      half_end   = (cnt_q == CNT_LAST);
      start      = LOAD && (state_q == S_IDLE || state_q == S_HELD);

      if (state_q != S_IDLE && state_q != S_HELD)
         cnt_d = half_end ? '0 : cnt_q + CNT_W'(1);

      case (state_q)
         S_IDLE, S_HELD: begin
            if (start) begin
               state_d    = S_LEAD;
               cnt_d      = '0;
               edge_cnt_d = '0;
               keep_d     = KEEP_CS;
               csx_d      = 1'b0;
               // CPHA=0 presents the MSB before the first leading edge.
               if (CPHA) begin
                  tx_d = IN;
               end else begin
                  tx_d  = {IN[DATA_WIDTH-2:0], 1'b0};
                  sdi_d = IN[DATA_WIDTH-1];
               end
            end else if (state_q == S_HELD && DROP_CS) begin
               state_d = S_GAP;
               cnt_d   = '0;
               csx_d   = 1'b1;
            end
         end
         S_LEAD: begin
            if (half_end) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (half_end) begin
               edge_cnt_d = edge_cnt_q + EDGE_W'(1);
               sck_d      = ~sck_q;
               // Even edge count means the upcoming edge is odd (leading).
               if (edge_cnt_q[0] == CPHA) begin
                  rx_d = {rx_q[DATA_WIDTH-2:0], SDO};
               end else if (edge_cnt_q != EDGE_PEN) begin
                  sdi_d = tx_q[DATA_WIDTH-1];
                  tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
               end
               if (edge_cnt_q == EDGE_PEN) state_d = S_TRAIL;
            end
         end
         S_TRAIL: begin
            if (half_end) begin
               out_d  = rx_q;
               done_d = 1'b1;
               if (keep_q) begin
                  state_d = S_HELD;
               end else begin
                  state_d = S_GAP;
                  csx_d   = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (half_end) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_LEAD) || (state_d == S_SHIFT) ||
               (state_d == S_TRAIL) || (state_d == S_GAP);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         edge_cnt_q <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         out_q      <= '0;
         keep_q     <= 1'b0;
         sck_q      <= CPOL;
         sdi_q      <= 1'b0;
         csx_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         edge_cnt_q <= edge_cnt_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         out_q      <= out_d;
         keep_q     <= keep_d;
         sck_q      <= sck_d;
         sdi_q      <= sdi_d;
         csx_q      <= csx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign OUT  = out_q;
   assign SCK  = sck_q;
   assign SDI  = sdi_q;
   assign CSX  = csx_q;

endmodule
